mips_mc_control: RTL and testbench
==================================

# mips_mc_control

Multicycle control sequencer for the team's MIPS datapath. It replaces the single-cycle control decode with a state machine that steps one instruction through fetch, decode, execute, memory and write-back. Memory accesses use a variable-latency request/ready handshake. The block sits between the shared instruction/data memory port and the datapath muxes, the register file, the ALU control and the PC. It drives every datapath enable and select signal, and it counts retired instructions.

## Interface
- No parameters; opcode, ALUOp and state encodings live in the package.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; high allows instruction issue
- opcode  in  6  instruction[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req / mem_we  out  1 / 1  memory request; write qualifier
- iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- ir_write, pc_write, reg_write  out  1 each  register enables
- reg_dst, mem_to_reg, alu_src_a  out  1 each  mux selects
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct field
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- busy  out  1  state is not IDLE
- illegal  out  1  sticky unknown-opcode flag
- retired  out  32  count of retired instructions

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, R_WB, ADDI_EX, ADDI_WB, BRANCH, JUMP, TRAP.
- Opcodes:
  - R = 000000
  - LW = 100011
  - SW = 101011
  - BEQ = 000100
  - J = 000010
  - ADDI = 001000
- Any other opcode in DECODE goes to TRAP. In TRAP, illegal = 1 and no enables are asserted. TRAP is left only by reset.
- IDLE: all outputs 0. Go to FETCH when run = 1.
- FETCH:
  - Always asserted: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - Asserted only while mem_ready = 1 (Mealy): ir_write and pc_write.
  - Stay in FETCH until mem_ready = 1, then go to DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Dispatch on opcode:
  - LW or SW → MEM_ADDR
  - R → EXEC
  - ADDI → ADDI_EX
  - BEQ → BRANCH
  - J → JUMP
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Go to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_req = 1, iord = 1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0.
- MEM_WR: mem_req = 1, mem_we = 1, iord = 1. Wait for mem_ready.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0.
- ADDI_EX: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
- ADDI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01, pc_write = zero.
- JUMP: pc_source = 10, pc_write = 1.
- Instruction completion: the final state of each instruction is MEM_WB, MEM_WR (on its mem_ready cycle), R_WB, ADDI_WB, BRANCH or JUMP. On that cycle:
  - retired increments by 1, wrapping from 0xFFFFFFFF to 0.
  - Next state is FETCH if run = 1, else IDLE.
- Dropping run mid-instruction never aborts the instruction; it stops issue at the next boundary.

## Timing
- Reset (asynchronous, any state): state = IDLE, every output = 0, retired = 0, illegal = 0, effective immediately with no clock needed.
- All outputs are Moore-decoded from registered state. The only exceptions are FETCH ir_write/pc_write, the BRANCH pc_write = zero term and mem_ready-dependent completion.
- Cycles per instruction with mem_ready tied high, counted from FETCH entry:
  - BEQ, J: 3
  - R, SW, ADDI: 4
  - LW: 5
- Each wait cycle on mem_ready adds exactly one cycle.
- mem_req stays asserted, with iord/mem_we stable, from request start until the mem_ready cycle inclusive. It is deasserted the cycle after mem_ready.
- run rising in IDLE: mem_req is asserted the following cycle.

## Structure
- mips_pkg: opcode localparams, state encoding, alu_op, alu_src_b and pc_source encodings; shared with the datapath and ALU control.
- One sub-module, mc_out_decode: purely combinational mapping of state, zero and mem_ready to the control outputs. The top module holds the state register, next-state logic, illegal flag and retired counter.

## Test plan
- Reset with run = 0: all outputs 0, busy = 0. Raise run → next cycle mem_req = 1, iord = 0, alu_src_b = 01.
- LW with mem_ready high: states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; reg_write and mem_to_reg high in cycle 5; retired 0 → 1.
- SW with mem_ready held low for 3 cycles in MEM_WR: mem_req = mem_we = iord = 1 for 4 cycles, no reg_write, total 7 cycles.
- BEQ twice: with zero = 1, pc_write = 1 and pc_source = 01 in cycle 3; with zero = 0, pc_write stays 0; retired increments in both cases.
- Opcode 111111: TRAP, illegal = 1, no enables, retired frozen. Async reset mid-cycle clears illegal immediately.
- Preload retired = 0xFFFFFFFF (force), retire J → 0. Deassert run during EXEC → R_WB completes, then IDLE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, sequencer
// states, ALU/mux select codes and the bundled control word.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC, S_R_WB, S_ADDI_EX, S_ADDI_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  // Every datapath enable/select driven by the sequencer.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// Combinational control-word decode: state plus the two Mealy terms
// (mem_ready in FETCH, zero in BRANCH) to datapath controls.
module mc_out_decode
  import mips_pkg::*;
(
  input  state_t i_state,
  input  logic   i_zero,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  // Map the current state to its control word; anything unlisted is all-zero.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_req   = 1'b1;
        o_ctrl.iord      = 1'b0;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.iord    = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.mem_we  = 1'b1;
        o_ctrl.iord    = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_ADDI_WB: begin
        o_ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_SUB;
        o_ctrl.pc_source = PCSRC_ALUOUT;
        o_ctrl.pc_write  = i_zero;
      end
      S_JUMP: begin
        o_ctrl.pc_source = PCSRC_JUMP;
        o_ctrl.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control sequencer: state register, next-state dispatch,
// sticky illegal-opcode flag and retired-instruction counter.
module mips_mc_control
  import mips_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_run,
  input  logic [5:0]  i_opcode,
  input  logic        i_zero,
  input  logic        i_mem_ready,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_iord,
  output logic        o_ir_write,
  output logic        o_pc_write,
  output logic        o_reg_write,
  output logic        o_reg_dst,
  output logic        o_mem_to_reg,
  output logic        o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [1:0]  o_alu_op,
  output logic [1:0]  o_pc_source,
  output logic        o_busy,
  output logic        o_illegal,
  output logic [31:0] o_retired
);

  state_t      r_state;
  state_t      w_next;
  logic        w_done;
  logic        r_illegal;
  logic [31:0] r_retired;
  ctrl_t       w_ctrl;

  mc_out_decode u_dec (
    .i_state     (r_state),
    .i_zero      (i_zero),
    .i_mem_ready (i_mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // Next-state dispatch; w_done marks the last cycle of an instruction,
  // where issue of the next one is decided by run.
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      S_IDLE:     if (i_run) w_next = S_FETCH;
      S_FETCH:    if (i_mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_R:         w_next = S_EXEC;
          OP_ADDI:      w_next = S_ADDI_EX;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: w_next = (i_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (i_mem_ready) w_next = S_MEM_WB;
      S_MEM_WR:   w_done = i_mem_ready;
      S_EXEC:     w_next = S_R_WB;
      S_ADDI_EX:  w_next = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: w_done = 1'b1;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_IDLE;
    endcase
    if (w_done) w_next = i_run ? S_FETCH : S_IDLE;
  end

  // State register, sticky illegal flag and wrapping retire counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_done) r_retired <= r_retired + 32'd1;
    end
  end

  assign o_mem_req    = w_ctrl.mem_req;
  assign o_mem_we     = w_ctrl.mem_we;
  assign o_iord       = w_ctrl.iord;
  assign o_ir_write   = w_ctrl.ir_write;
  assign o_pc_write   = w_ctrl.pc_write;
  assign o_reg_write  = w_ctrl.reg_write;
  assign o_reg_dst    = w_ctrl.reg_dst;
  assign o_mem_to_reg = w_ctrl.mem_to_reg;
  assign o_alu_src_a  = w_ctrl.alu_src_a;
  assign o_alu_src_b  = w_ctrl.alu_src_b;
  assign o_alu_op     = w_ctrl.alu_op;
  assign o_pc_source  = w_ctrl.pc_source;
  assign o_busy       = (r_state != S_IDLE);
  assign o_illegal    = r_illegal;
  assign o_retired    = r_retired;

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for the multicycle control sequencer: a per-instruction step-table
// model checked every negedge, plus directed literal checks.
module tb_mips_mc_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a, busy, illegal;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [31:0] retired;

  int n_checks = 0;
  int n_errors = 0;
  logic tb_preload = 1'b0;

  mips_mc_control dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_opcode(opcode),
    .i_zero(zero), .i_mem_ready(mem_ready),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_iord(iord),
    .o_ir_write(ir_write), .o_pc_write(pc_write), .o_reg_write(reg_write),
    .o_reg_dst(reg_dst), .o_mem_to_reg(mem_to_reg), .o_alu_src_a(alu_src_a),
    .o_alu_src_b(alu_src_b), .o_alu_op(alu_op), .o_pc_source(pc_source),
    .o_busy(busy), .o_illegal(illegal), .o_retired(retired)
  );

  initial forever #5 clk = ~clk;

  logic [16:0] dut_vec;
  assign dut_vec = {mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst,
                    mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, busy, illegal};

  // ---------------- instruction-level model ----------------
  localparam int K_NONE = 0, K_LW = 1, K_SW = 2, K_R = 3, K_ADDI = 4, K_BEQ = 5, K_J = 6, K_BAD = 7;
  localparam int C_NONE = -1, C_F = 0, C_D = 1, C_ADDR = 2, C_RD = 3, C_MWB = 4, C_WR = 5,
                 C_EX = 6, C_RWB = 7, C_AEX = 8, C_AWB = 9, C_BR = 10, C_JMP = 11;

  function automatic int kind_of(logic [5:0] op);
    case (op)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000: return K_R;
      6'b001000: return K_ADDI;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      default:   return K_BAD;
    endcase
  endfunction

  // Ordered step list of each instruction kind.
  function automatic int step_code(int k, int s);
    if (s == 0) return C_F;
    if (s == 1) return C_D;
    case (k)
      K_LW:    return (s == 2) ? C_ADDR : (s == 3) ? C_RD : C_MWB;
      K_SW:    return (s == 2) ? C_ADDR : C_WR;
      K_R:     return (s == 2) ? C_EX : C_RWB;
      K_ADDI:  return (s == 2) ? C_AEX : C_AWB;
      K_BEQ:   return C_BR;
      K_J:     return C_JMP;
      default: return C_NONE;
    endcase
  endfunction

  function automatic int last_step(int k);
    case (k)
      K_LW:         return 4;
      K_BEQ, K_J:   return 2;
      default:      return 3;
    endcase
  endfunction

  function automatic logic [16:0] exp_vec(int c, logic z, logic rdy, logic bsy, logic ill);
    logic mreq, mwe, io, irw, pcw, rw, rd, m2r, sa;
    logic [1:0] sb, ao, ps;
    {mreq, mwe, io, irw, pcw, rw, rd, m2r, sa} = '0;
    sb = 2'd0; ao = 2'd0; ps = 2'd0;
    case (c)
      C_F:    begin mreq = 1; sb = 2'd1; irw = rdy; pcw = rdy; end
      C_D:    sb = 2'd3;
      C_ADDR: begin sa = 1; sb = 2'd2; end
      C_RD:   begin mreq = 1; io = 1; end
      C_MWB:  begin rw = 1; m2r = 1; end
      C_WR:   begin mreq = 1; mwe = 1; io = 1; end
      C_EX:   begin sa = 1; ao = 2'd2; end
      C_RWB:  begin rw = 1; rd = 1; end
      C_AEX:  begin sa = 1; sb = 2'd2; end
      C_AWB:  rw = 1;
      C_BR:   begin sa = 1; ao = 2'd1; ps = 2'd1; pcw = z; end
      C_JMP:  begin ps = 2'd2; pcw = 1; end
      default: ;
    endcase
    return {mreq, mwe, io, irw, pcw, rw, rd, m2r, sa, sb, ao, ps, bsy, ill};
  endfunction

  int          m_mode = 0;   // 0 idle, 1 executing, 2 trapped
  int          m_step = 0;
  int          m_kind = K_NONE;
  logic [31:0] m_ret = '0;
  logic        m_ill = 1'b0;

  // Model advance on each clock edge, async reset on rst_n fall.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_step = 0; m_kind = K_NONE; m_ret = '0; m_ill = 1'b0;
    end else begin
      if (tb_preload) m_ret = 32'hFFFF_FFFF;
      if (m_mode == 0) begin
        if (run) begin m_mode = 1; m_step = 0; m_kind = K_NONE; end
      end else if (m_mode == 1) begin
        int sc;
        sc = step_code(m_kind, m_step);
        if ((sc == C_F || sc == C_RD || sc == C_WR) && !mem_ready) begin
          // waiting on memory
        end else if (m_step == 1) begin
          if (kind_of(opcode) == K_BAD) begin m_mode = 2; m_ill = 1'b1; end
          else begin m_kind = kind_of(opcode); m_step = 2; end
        end else if (m_step == last_step(m_kind)) begin
          m_ret = m_ret + 32'd1;
          if (run) begin m_step = 0; m_kind = K_NONE; end
          else m_mode = 0;
        end else begin
          m_step = m_step + 1;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    logic [16:0] ev;
    @(negedge clk);
    ev = exp_vec((m_mode == 1) ? step_code(m_kind, m_step) : C_NONE,
                 zero, mem_ready, m_mode != 0, m_ill);
    n_checks++;
    if (dut_vec !== ev) begin
      n_errors++;
      $display("FAIL ctrl_word t=%0t got %b exp %b", $time, dut_vec, ev);
    end
    n_checks++;
    if (retired !== m_ret) begin
      n_errors++;
      $display("FAIL retired_model t=%0t got %h exp %h", $time, retired, m_ret);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_beq(logic z, logic exp_pcw, logic [31:0] exp_ret);
    opcode = 6'b000100; zero = z; run = 1; mem_ready = 1;
    tick; run = 0;
    tick; tick;
    @(negedge clk);
    chk("beq_pc_write", {31'd0, pc_write}, {31'd0, exp_pcw});
    chk("beq_pc_source", {30'd0, pc_source}, 32'd1);
    tick; @(negedge clk);
    chk("beq_retired", retired, exp_ret);
  endtask

  initial begin
    int cnt, wr;
    #12;
    chk("reset_outs", {15'd0, dut_vec}, 32'd0);
    chk("reset_retired", retired, 32'd0);
    tick; rst_n = 1;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // LW, mem_ready high
    run = 1; opcode = 6'b100011; mem_ready = 1;
    tick; run = 0;
    @(negedge clk);
    chk("fetch_mem_req", {31'd0, mem_req}, 32'd1);
    chk("fetch_iord", {31'd0, iord}, 32'd0);
    chk("fetch_src_b", {30'd0, alu_src_b}, 32'd1);
    repeat (4) tick;
    @(negedge clk);
    chk("lw_wb", {30'd0, reg_write, mem_to_reg}, 32'd3);
    tick; @(negedge clk);
    chk("lw_retired", retired, 32'd1);
    chk("lw_idle", {31'd0, busy}, 32'd0);

    // SW with three memory wait cycles
    opcode = 6'b101011; run = 1; mem_ready = 1;
    tick; run = 0;
    tick; tick; mem_ready = 0;
    cnt = 0; wr = 0;
    for (int i = 0; i < 4; i++) begin
      tick; mem_ready = (i == 3);
      @(negedge clk);
      if (mem_req && mem_we && iord) cnt++;
      if (reg_write) wr++;
    end
    chk("sw_req_cycles", cnt, 32'd4);
    chk("sw_no_reg_write", wr, 32'd0);
    tick; @(negedge clk);
    chk("sw_idle_after_7", {31'd0, busy}, 32'd0);
    chk("sw_retired", retired, 32'd2);

    do_beq(1'b1, 1'b1, 32'd3);
    do_beq(1'b0, 1'b0, 32'd4);

    // R-type, run dropped during EXEC
    opcode = 6'b000000; run = 1;
    tick; tick; tick; run = 0;
    tick; @(negedge clk);
    chk("r_wb", {30'd0, reg_write, reg_dst}, 32'd3);
    tick; @(negedge clk);
    chk("r_then_idle", {31'd0, busy}, 32'd0);
    chk("r_retired", retired, 32'd5);

    // ADDI then J back to back
    opcode = 6'b001000; run = 1;
    repeat (4) tick;
    opcode = 6'b000010;
    tick; run = 0;
    tick; tick; @(negedge clk);
    chk("j_pc", {29'd0, pc_write, pc_source}, 32'd6);
    tick; @(negedge clk);
    chk("addi_j_retired", retired, 32'd7);

    // Counter wrap
    tb_preload = 1;
    @(posedge clk);
    force dut.r_retired = 32'hFFFF_FFFF;
    #1 release dut.r_retired;
    tb_preload = 0;
    @(negedge clk);
    chk("preload", retired, 32'hFFFF_FFFF);
    opcode = 6'b000010; run = 1;
    tick; run = 0;
    tick; tick; tick; @(negedge clk);
    chk("retired_wrap", retired, 32'd0);

    // Illegal opcode -> TRAP
    opcode = 6'b111111; run = 1;
    tick; run = 0;
    tick; tick; @(negedge clk);
    chk("trap_illegal", {30'd0, illegal, busy}, 32'd3);
    chk("trap_no_enables", {27'd0, mem_req, ir_write, pc_write, reg_write, mem_we}, 32'd0);
    run = 1;
    repeat (3) tick;
    @(negedge clk);
    chk("trap_retired_frozen", retired, 32'd0);
    chk("trap_sticky", {31'd0, illegal}, 32'd1);
    tick; #1 rst_n = 0;
    #1;
    chk("async_rst_illegal", {30'd0, illegal, busy}, 32'd0);
    run = 0;
    tick; rst_n = 1;
    repeat (2) tick;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
